// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences kernel load, settle, activation streaming and drain for the systolic MAC array.
module mac_array_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_load,
  input  logic [cnt_bw-1:0] num_act,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  input  logic [col-1:0]    valid,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE} state_t;
  localparam logic [cnt_bw-1:0] load_last = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] settle_last = cnt_bw'(row + col - 1);
  localparam logic [cnt_bw-1:0] one = cnt_bw'(1);
  state_t state, state_n;
  logic [cnt_bw-1:0] act_q, cnt, cnt_n, out_cnt, out_cnt_n;
  logic v, drained;
  always_comb begin
    v = valid[col-1];
    l0_rd = (state == LOAD || state == EXEC) && !l0_empty;
    busy = state != IDLE;
    done = state == DONE;
    drained = ({1'b0, out_cnt} + {{cnt_bw{1'b0}}, v}) >= {1'b0, act_q};
    state_n = state;
    cnt_n = cnt;
    // out_cnt only lives in EXEC/DRAIN, so it is zero on every entry to EXEC
    out_cnt_n = (state == EXEC || state == DRAIN) ? out_cnt + ((v && out_cnt != act_q) ? one : '0) : '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = !skip_load ? LOAD : (num_act != '0 ? EXEC : DONE);
      end
      LOAD: if (l0_rd) begin
        cnt_n = cnt == load_last ? '0 : cnt + one;
        state_n = cnt == load_last ? SETTLE : LOAD;
      end
      SETTLE: begin
        cnt_n = cnt == settle_last ? '0 : cnt + one;
        if (cnt == settle_last) state_n = act_q != '0 ? EXEC : DONE;
      end
      EXEC: if (l0_rd) begin
        cnt_n = cnt == act_q - one ? '0 : cnt + one;
        state_n = cnt == act_q - one ? DRAIN : EXEC;
      end
      DRAIN: if (drained) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      out_cnt <= '0;
      act_q <= '0;
      inst_w <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_cnt <= out_cnt_n;
      inst_w <= {state == EXEC && l0_rd, state == LOAD && l0_rd};
      if (state == IDLE && start) act_q <= num_act;
    end
  end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed job scenarios, per-cycle traces checked against hand-derived timings.
module tb_mac_array_ctrl;
  logic clk = 0, reset = 1, start = 0, skip_load = 0, l0_empty = 0;
  logic [7:0] num_act = 0;
  logic [7:0] valid = 8'h2a;
  logic l0_rd, busy, done;
  logic [1:0] inst_w;
  int checks = 0, failures = 0;
  bit tr_rd[128], tr_bz[128], tr_dn[128];
  logic [1:0] tr_iw[128];
  int imm_rd, imm_iw, imm_bz, imm_dn;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(8), .col(8), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .skip_load(skip_load), .num_act(num_act),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst_w(inst_w), .valid(valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int n_rd(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(tr_rd[i]);
    return n;
  endfunction

  function automatic int n_iw(input logic [1:0] w, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += (tr_iw[i] === w) ? 1 : 0;
    return n;
  endfunction

  function automatic int first_iw(input logic [1:0] w);
    for (int i = 0; i < 128; i++) if (tr_iw[i] === w) return i;
    return -1;
  endfunction

  function automatic int last_iw(input logic [1:0] w);
    for (int i = 127; i >= 0; i--) if (tr_iw[i] === w) return i;
    return -1;
  endfunction

  function automatic int first_dn();
    for (int i = 0; i < 128; i++) if (tr_dn[i]) return i;
    return -1;
  endfunction

  function automatic int n_dn();
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(tr_dn[i]);
    return n;
  endfunction

  // cycle 0 carries the start pulse; entered and left just after a rising edge
  task automatic run_job(input logic sk, input logic [7:0] n, input int e_lo, input int e_hi,
                         input int v_lo, input int v_n, input int s2, input int r_at, input int ncyc);
    for (int i = 0; i < 128; i++) begin
      tr_rd[i] = 0; tr_bz[i] = 0; tr_dn[i] = 0; tr_iw[i] = 2'b00;
    end
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == s2);
      num_act = (c == s2) ? 8'd1 : n;
      skip_load = sk;
      l0_empty = (c >= e_lo) && (c <= e_hi);
      valid = {(c >= v_lo) && (c < v_lo + v_n), 7'h2a};
      if (c == r_at) reset = 1;
      if (c == r_at + 3) reset = 0;
      #1;
      if (c == r_at) begin
        imm_rd = int'(l0_rd); imm_iw = int'(inst_w); imm_bz = int'(busy); imm_dn = int'(done);
      end
      @(negedge clk);
      tr_rd[c] = l0_rd; tr_iw[c] = inst_w; tr_bz[c] = busy; tr_dn[c] = done;
      @(posedge clk);
      #1;
    end
    start = 0; l0_empty = 0; valid = 8'h2a;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", int'(l0_rd), 0);
    chk("rst_iw", int'(inst_w), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    run_job(0, 8'd4, -1, -1, 999, 0, -1, 3, 12);
    chk("s1_rd_pre", int'(tr_rd[2]), 1);
    chk("s1_iw_pre", int'(tr_iw[2]), 1);
    chk("s1_imm_rd", imm_rd, 0);
    chk("s1_imm_iw", imm_iw, 0);
    chk("s1_imm_busy", imm_bz, 0);
    chk("s1_imm_done", imm_dn, 0);
    chk("s1_idle_rd", n_rd(6, 11), 0);
    chk("s1_idle_busy", int'(tr_bz[11]), 0);
    chk("s1_no_done", n_dn(), 0);

    run_job(0, 8'd4, -1, -1, 40, 4, -1, -1, 60);
    chk("s2_load_rd", n_rd(1, 8), 8);
    chk("s2_settle_rd", n_rd(9, 24), 0);
    chk("s2_exec_rd", n_rd(25, 28), 4);
    chk("s2_tail_rd", n_rd(29, 59), 0);
    chk("s2_iw1_first", first_iw(2'b01), 2);
    chk("s2_iw1_last", last_iw(2'b01), 9);
    chk("s2_iw1_cnt", n_iw(2'b01, 0, 59), 8);
    chk("s2_iw2_first", first_iw(2'b10), 26);
    chk("s2_iw2_last", last_iw(2'b10), 29);
    chk("s2_iw2_cnt", n_iw(2'b10, 0, 59), 4);
    chk("s2_done_at", first_dn(), 44);
    chk("s2_done_cnt", n_dn(), 1);
    chk("s2_busy_44", int'(tr_bz[44]), 1);
    chk("s2_busy_45", int'(tr_bz[45]), 0);

    run_job(0, 8'd4, 3, 5, 43, 4, -1, -1, 60);
    chk("s3_stall_rd", n_rd(3, 5), 0);
    chk("s3_stall_iw", n_iw(2'b01, 4, 6), 0);
    chk("s3_iw1_cnt", n_iw(2'b01, 0, 59), 8);
    chk("s3_iw1_last", last_iw(2'b01), 12);
    chk("s3_settle_rd", n_rd(12, 27), 0);
    chk("s3_iw2_first", first_iw(2'b10), 29);
    chk("s3_done_at", first_dn(), 47);

    run_job(1, 8'd2, -1, -1, 5, 2, -1, -1, 20);
    chk("s4_iw1_cnt", n_iw(2'b01, 0, 19), 0);
    chk("s4_rd_cnt", n_rd(1, 2), 2);
    chk("s4_rd_total", n_rd(0, 19), 2);
    chk("s4_iw2_first", first_iw(2'b10), 2);
    chk("s4_iw2_last", last_iw(2'b10), 3);
    chk("s4_done_at", first_dn(), 7);

    run_job(1, 8'd2, -1, -1, 1, 2, -1, -1, 12);
    chk("s4b_done_at", first_dn(), 4);
    chk("s4b_done_cnt", n_dn(), 1);

    run_job(0, 8'd0, -1, -1, 999, 0, -1, -1, 40);
    chk("s5a_iw1_cnt", n_iw(2'b01, 0, 39), 8);
    chk("s5a_iw2_cnt", n_iw(2'b10, 0, 39), 0);
    chk("s5a_rd_total", n_rd(0, 39), 8);
    chk("s5a_done_at", first_dn(), 25);

    run_job(1, 8'd0, -1, -1, 999, 0, -1, -1, 10);
    chk("s5b_done_at", first_dn(), 1);
    chk("s5b_rd_total", n_rd(0, 9), 0);
    chk("s5b_busy_2", int'(tr_bz[2]), 0);

    run_job(0, 8'd4, -1, -1, 40, 4, 26, -1, 60);
    chk("s6a_iw2_cnt", n_iw(2'b10, 0, 59), 4);
    chk("s6a_iw1_cnt", n_iw(2'b01, 0, 59), 8);
    chk("s6a_done_at", first_dn(), 44);
    chk("s6a_done_cnt", n_dn(), 1);
    chk("s6a_busy_46", int'(tr_bz[46]), 0);

    run_job(0, 8'd4, -1, -1, 40, 4, -1, 27, 60);
    chk("s6b_iw_pre", int'(tr_iw[27]), 0);
    chk("s6b_iw_26", int'(tr_iw[26]), 2);
    chk("s6b_imm_rd", imm_rd, 0);
    chk("s6b_imm_iw", imm_iw, 0);
    chk("s6b_imm_busy", imm_bz, 0);
    chk("s6b_no_done", n_dn(), 0);
    chk("s6b_idle_rd", n_rd(28, 59), 0);

    run_job(0, 8'd4, -1, -1, 40, 4, -1, -1, 60);
    chk("s6c_done_at", first_dn(), 44);
    chk("s6c_iw1_cnt", n_iw(2'b01, 0, 59), 8);
    chk("s6c_iw2_cnt", n_iw(2'b10, 0, 59), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
Sequencer for the systolic MAC array. On a start pulse it reads a kernel tile from the L0 buffer in kernel-load mode, waits for the weights to settle, then streams a programmable number of activation vectors in execute mode. It counts output-valid pulses from the array's last column and pulses done once every result has left the array. It sits between the core's top-level control and the mac_array/L0 pair, and it owns the inst_w bus.

Parameters:
row, 8, array rows (input lanes)
col, 8, array columns; one kernel load takes col L0 reads
cnt_bw, 8, width of the activation count and the internal counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle job request, accepted only in IDLE
skip_load  in  1  sampled with start; 1 = reuse resident kernel, no load phase
num_act  in  cnt_bw  activation vectors for this job, sampled with start
l0_empty  in  1  L0 buffer empty
l0_rd  out  1  L0 read strobe; data is valid the following cycle
inst_w  out  2  array instruction: bit1 execute, bit0 kernel load
valid  in  col  array output valid; only valid[col-1] is used
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous and active-high. It forces state IDLE and clears every counter. While reset is asserted and after release: l0_rd=0, inst_w=00, busy=0, done=0. Reset asserted mid-job abandons the job with no done pulse.
- States: IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE.
- Latching: num_act and skip_load are captured on an accepted start.
- Start while busy is ignored and has no effect on the running job.
- IDLE transitions on start:
  - skip_load=0 -> LOAD
  - skip_load=1 and num_act>0 -> EXEC
  - skip_load=1 and num_act=0 -> DONE
- l0_rd (combinational) = (state==LOAD or EXEC) and !l0_empty.
- inst_w (registered): inst_w <= {EXEC & l0_rd, LOAD & l0_rd}. It therefore lags each read by exactly one cycle, aligned with the L0 data. Outside those cycles inst_w=00.
- LOAD:
  - rd_cnt counts accepted reads.
  - When l0_empty=1, no read is issued and the counter holds (stall).
  - After the col-th read, go to SETTLE.
- SETTLE:
  - Fixed row+col cycles with inst_w=00 after the last load read; this lets the load instruction ripple through every row.
  - Then go to EXEC if num_act>0, otherwise to DONE.
- EXEC:
  - Same read/stall rules as LOAD.
  - After the num_act-th read, go to DRAIN.
- out_cnt:
  - Cleared on entry to EXEC.
  - Increments on each cycle with valid[col-1]=1 while in EXEC or DRAIN.
  - Saturates at num_act.
  - valid pulses in any other state are ignored.
- DRAIN exits to DONE in the cycle where out_cnt + valid[col-1] >= num_act. This includes the case where all pulses already arrived during EXEC, in which case DRAIN lasts one cycle.
- DONE lasts 1 cycle with done=1 and busy=1, then goes to IDLE.
- Only IDLE accepts a new start; the earliest new start is the cycle after DONE.
- Counters are cnt_bw wide. num_act up to 2^cnt_bw-1 is legal, and no wrap may occur.

Test Plan:
1. Reset: assert reset mid-cycle with no clock edge -> l0_rd, inst_w, busy and done go to 0 immediately; state is IDLE after release.
2. Full job: row=col=8, num_act=4, l0_empty=0, start at cycle t. Required response:
   - l0_rd=1 t+1..t+8, with inst_w=01 t+2..t+9.
   - SETTLE t+9..t+24.
   - l0_rd=1 t+25..t+28, with inst_w=10 t+26..t+29.
   - Drive 4 valid[7] pulses at t+40..t+43 -> done=1 at t+44 only, busy falls at t+45.
3. Load stall: as scenario 2 but l0_empty=1 at t+3..t+5 -> l0_rd=0 and inst_w=00 one cycle later (t+4..t+6); the load still totals 8 reads, and SETTLE starts 3 cycles later (t+12).
4. Skip load: skip_load=1, num_act=2, start at t -> no inst_w=01 ever; l0_rd=1 t+1..t+2, inst_w=10 t+2..t+3.
5. Edge counts:
   - num_act=0, skip_load=0 -> 8 load reads, 16 SETTLE cycles, then done with no execute read.
   - num_act=0, skip_load=1 -> done at t+1.
6. Contention and abort: pulse start during EXEC -> ignored, num_act unchanged, exactly one done. Separately, reset during EXEC -> outputs 0, no done; a fresh start then runs a complete job.
